// File: rtl/lsu_pkg.sv
// -----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the load/store unit memory initiator:
//   - RISC-V load/store funct3 encodings (F3LB .. F3SW)
//   - FSM state encodings and the state enum built from them
//   - access-size decode and word-boundary split helpers
// Optional build macro LSU_MISALIGN_TRAP_EN removes the second-beat states.
// -----------------------------------------------------------------------------
package lsu_pkg;

    // Load encodings
    localparam logic [2:0] F3LB  = 3'b000;
    localparam logic [2:0] F3LH  = 3'b001;
    localparam logic [2:0] F3LW  = 3'b010;
    localparam logic [2:0] F3LBU = 3'b100;
    localparam logic [2:0] F3LHU = 3'b101;

    // Store encodings
    localparam logic [2:0] F3SB  = 3'b000;
    localparam logic [2:0] F3SH  = 3'b001;
    localparam logic [2:0] F3SW  = 3'b010;

    // State encodings
    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ISSUE0 = 3'd1;
    localparam logic [2:0] ST_WAIT0  = 3'd2;
    localparam logic [2:0] ST_RESP   = 3'd3;
    localparam logic [2:0] ST_ISSUE1 = 3'd4;
    localparam logic [2:0] ST_WAIT1  = 3'd5;

    typedef enum logic [2:0] {
        IDLE   = ST_IDLE,
        ISSUE0 = ST_ISSUE0,
        WAIT0  = ST_WAIT0,
        RESP   = ST_RESP
`ifndef LSU_MISALIGN_TRAP_EN
        ,
        ISSUE1 = ST_ISSUE1,
        WAIT1  = ST_WAIT1
`endif
    } lsu_state_t;

    // Access size in bytes: 1, 2 or 4. The 2'b11 code is rejected before use.
    function automatic logic [2:0] f3_size(input logic [2:0] f3);
        case (f3[1:0])
            2'b00:   return 3'd1;
            2'b01:   return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // True when the access spills past the end of its 32-bit word.
    function automatic logic f3_split(input logic [2:0] f3, input logic [1:0] off);
        return ({2'b00, off} + {1'b0, f3_size(f3)}) > 4'd4;
    endfunction

endpackage

// File: rtl/lsu_mem_initiator_if.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator_if
// Bundles the pipeline request/response handshake and the data-memory word
// interface of the load/store unit.
//   Pipeline : REQ_VALID, REQ_READY, MRd, MWrt, FUNC3, IN_ADDR, W_DATA,
//              RSP_VALID, RSP_DATA, RSP_ERR
//   Memory   : M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA, M_GNT, M_RVALID, M_RDATA
// Modports:
//   master - the load/store unit (drives memory beats and pipeline responses)
//   slave  - the surroundings (pipeline requests and memory responses)
// -----------------------------------------------------------------------------
interface lsu_mem_initiator_if #(
    parameter int unsigned AW = 32
);
    // Pipeline side
    logic          REQ_VALID;
    logic          REQ_READY;
    logic          MRd;
    logic          MWrt;
    logic [2:0]    FUNC3;
    logic [AW-1:0] IN_ADDR;
    logic [31:0]   W_DATA;
    logic          RSP_VALID;
    logic [31:0]   RSP_DATA;
    logic          RSP_ERR;

    // Memory side
    logic          M_REQ;
    logic          M_WE;
    logic [AW-3:0] M_ADDR;
    logic [3:0]    M_WSTRB;
    logic [31:0]   M_WDATA;
    logic          M_GNT;
    logic          M_RVALID;
    logic [31:0]   M_RDATA;

    modport master (
        input  REQ_VALID, MRd, MWrt, FUNC3, IN_ADDR, W_DATA,
        output REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        output M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA,
        input  M_GNT, M_RVALID, M_RDATA
    );

    modport slave (
        output REQ_VALID, MRd, MWrt, FUNC3, IN_ADDR, W_DATA,
        input  REQ_READY, RSP_VALID, RSP_DATA, RSP_ERR,
        input  M_REQ, M_WE, M_ADDR, M_WSTRB, M_WDATA,
        output M_GNT, M_RVALID, M_RDATA
    );

endinterface

// File: rtl/lsu_lane_align.sv
// -----------------------------------------------------------------------------
// lsu_lane_align
// Purely combinational byte-lane steering for the load/store unit.
//   func3  : RISC-V load/store funct3
//   off    : byte offset within the first word (address bits [1:0])
//   w_data : right-aligned store data
//   word0  : read data of the first beat
//   word1  : read data of the second beat (zero when the access is not split)
//   mask8  : byte-lane mask across both beats, [3:0] beat0, [7:4] beat1
//   wdata0 : store data steered onto beat0 lanes
//   wdata1 : store data that overflows into beat1 lanes
//   rdata  : merged, shifted and sign/zero-extended load result
// -----------------------------------------------------------------------------
module lsu_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]  func3,
    input  logic [1:0]  off,
    input  logic [31:0] w_data,
    input  logic [31:0] word0,
    input  logic [31:0] word1,
    output logic [7:0]  mask8,
    output logic [31:0] wdata0,
    output logic [31:0] wdata1,
    output logic [31:0] rdata
);

    logic [3:0]  base;
    logic [5:0]  sh;
    logic [31:0] v;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned, which would otherwise infer a latch.
        base = 4'b0000;
        case (f3_size(func3))
            3'd1:    base = 4'b0001;
            3'd2:    base = 4'b0011;
            3'd4:    base = 4'b1111;
            default: base = 4'b0000;
        endcase

        mask8 = {4'b0000, base} << off;

        sh     = {1'b0, off, 3'b000};
        wdata0 = w_data << sh;
        // For off == 0 the shift is 32 and the result is zero, but beat1
        // never issues in that case.
        wdata1 = w_data >> (6'd32 - sh);

        v = 32'({word1, word0} >> sh);

        case (func3)
            F3LB:    rdata = {{24{v[7]}}, v[7:0]};
            F3LH:    rdata = {{16{v[15]}}, v[15:0]};
            F3LW:    rdata = v;
            F3LBU:   rdata = {24'h000000, v[7:0]};
            F3LHU:   rdata = {16'h0000, v[15:0]};
            default: rdata = v;
        endcase
    end

endmodule

// File: rtl/lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// lsu_mem_initiator
// Load/store unit that turns one pipeline load/store into one or two
// word-addressed, byte-strobed memory beats and returns one response.
//   CLK, RESET_N : clock, asynchronous active-low reset
//   bus (master) : pipeline request/response + memory beat interface
// Parameters:
//   TIMEOUT : max cycles to wait for M_RVALID per beat (0 = wait forever)
//   AW      : byte-address width (memory word address is AW-2 bits)
// Build option:
//   LSU_MISALIGN_TRAP_EN - word-crossing accesses respond with RSP_ERR and
//   issue no beat; the second-beat states are removed.
// -----------------------------------------------------------------------------
module lsu_mem_initiator
    import lsu_pkg::*;
#(
    parameter int unsigned TIMEOUT = 255,
    parameter int unsigned AW      = 32
) (
    input  logic                CLK,
    input  logic                RESET_N,
    lsu_mem_initiator_if.master bus
);

    localparam int unsigned TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    lsu_state_t    state;
    logic [2:0]    f3_q;
    logic [AW-1:0] addr_q;
    logic [31:0]   wdata_q;
    logic          we_q;
    logic [31:0]   word0_q;
    logic [TW-1:0] tcnt;

    logic [2:0]    sel_f3;
    logic [1:0]    sel_off;
    logic [31:0]   sel_wdata;
    logic [31:0]   rd_word0;
    logic [31:0]   rd_word1;
    logic [7:0]    mask8;
    logic [31:0]   wdata0;
    logic [31:0]   wdata1;
    logic [31:0]   load_data;
    logic          in_illegal;
    logic          timeout_hit;
`ifndef LSU_MISALIGN_TRAP_EN
    logic          cur_split;
`endif

    // In IDLE the aligner looks at the live request so beat0 can be
    // registered on the acceptance edge; afterwards it uses the captured copy.
    always_comb begin
        sel_f3    = (state == IDLE) ? bus.FUNC3        : f3_q;
        sel_off   = (state == IDLE) ? bus.IN_ADDR[1:0] : addr_q[1:0];
        sel_wdata = (state == IDLE) ? bus.W_DATA       : wdata_q;

        // The completing beat's data is used straight off the bus so the
        // response can be registered on the same edge.
        rd_word0 = (state == WAIT0) ? bus.M_RDATA : word0_q;
`ifndef LSU_MISALIGN_TRAP_EN
        rd_word1 = (state == WAIT1) ? bus.M_RDATA : 32'h0;
`else
        rd_word1 = 32'h0;
`endif

        in_illegal = (bus.MRd && bus.MWrt)
                   || (bus.MRd  && (bus.FUNC3[1:0] == 2'b11))
                   || (bus.MWrt && !(bus.FUNC3 inside {F3SB, F3SH, F3SW}));
`ifdef LSU_MISALIGN_TRAP_EN
        in_illegal = in_illegal || f3_split(bus.FUNC3, bus.IN_ADDR[1:0]);
`endif

        timeout_hit = (TIMEOUT != 0) && (tcnt == TW'(TIMEOUT - 1));
    end

`ifndef LSU_MISALIGN_TRAP_EN
    assign cur_split = f3_split(f3_q, addr_q[1:0]);
`endif

    lsu_lane_align u_align (
        .func3  (sel_f3),
        .off    (sel_off),
        .w_data (sel_wdata),
        .word0  (rd_word0),
        .word1  (rd_word1),
        .mask8  (mask8),
        .wdata0 (wdata0),
        .wdata1 (wdata1),
        .rdata  (load_data)
    );

    // NOTE: all state and registered outputs use non-blocking assignments so
    // every register samples the pre-edge values, independent of statement order.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            // NOTE: the capture registers are reset too; they are few and a
            // known value keeps the merge path free of X after reset.
            state         <= IDLE;
            f3_q          <= '0;
            addr_q        <= '0;
            wdata_q       <= '0;
            we_q          <= 1'b0;
            word0_q       <= '0;
            tcnt          <= '0;
            bus.REQ_READY <= 1'b1;
            bus.RSP_VALID <= 1'b0;
            bus.RSP_DATA  <= '0;
            bus.RSP_ERR   <= 1'b0;
            bus.M_REQ     <= 1'b0;
            bus.M_WE      <= 1'b0;
            bus.M_ADDR    <= '0;
            bus.M_WSTRB   <= '0;
            bus.M_WDATA   <= '0;
        end else begin
            bus.RSP_VALID <= 1'b0;

            case (state)
                IDLE: begin
                    if (bus.REQ_VALID && (bus.MRd || bus.MWrt)) begin
                        f3_q          <= bus.FUNC3;
                        addr_q        <= bus.IN_ADDR;
                        wdata_q       <= bus.W_DATA;
                        we_q          <= bus.MWrt;
                        bus.REQ_READY <= 1'b0;
                        if (in_illegal) begin
                            state         <= RESP;
                            bus.RSP_VALID <= 1'b1;
                            bus.RSP_ERR   <= 1'b1;
                            bus.RSP_DATA  <= '0;
                        end else begin
                            state       <= ISSUE0;
                            bus.M_REQ   <= 1'b1;
                            bus.M_WE    <= bus.MWrt;
                            bus.M_ADDR  <= bus.IN_ADDR[AW-1:2];
                            bus.M_WSTRB <= bus.MWrt ? mask8[3:0] : 4'b0000;
                            bus.M_WDATA <= bus.MWrt ? wdata0 : 32'h0;
                        end
                    end
                end

                ISSUE0: begin
                    if (bus.M_GNT) begin
                        bus.M_REQ <= 1'b0;
                        tcnt      <= '0;
                        state     <= WAIT0;
                    end
                end

                WAIT0: begin
                    if (bus.M_RVALID) begin
                        word0_q <= bus.M_RDATA;
`ifndef LSU_MISALIGN_TRAP_EN
                        if (cur_split) begin
                            state       <= ISSUE1;
                            bus.M_REQ   <= 1'b1;
                            bus.M_ADDR  <= addr_q[AW-1:2] + (AW-2)'(1);
                            bus.M_WSTRB <= we_q ? mask8[7:4] : 4'b0000;
                            bus.M_WDATA <= we_q ? wdata1 : 32'h0;
                        end else
`endif
                        begin
                            state         <= RESP;
                            bus.RSP_VALID <= 1'b1;
                            bus.RSP_ERR   <= 1'b0;
                            bus.RSP_DATA  <= we_q ? 32'h0 : load_data;
                        end
                    end else if (timeout_hit) begin
                        state         <= RESP;
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_DATA  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end

`ifndef LSU_MISALIGN_TRAP_EN
                ISSUE1: begin
                    if (bus.M_GNT) begin
                        bus.M_REQ <= 1'b0;
                        tcnt      <= '0;
                        state     <= WAIT1;
                    end
                end

                WAIT1: begin
                    if (bus.M_RVALID) begin
                        state         <= RESP;
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_ERR   <= 1'b0;
                        bus.RSP_DATA  <= we_q ? 32'h0 : load_data;
                    end else if (timeout_hit) begin
                        state         <= RESP;
                        bus.RSP_VALID <= 1'b1;
                        bus.RSP_ERR   <= 1'b1;
                        bus.RSP_DATA  <= '0;
                    end else begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
`endif

                RESP: begin
                    state         <= IDLE;
                    bus.REQ_READY <= 1'b1;
                    bus.RSP_ERR   <= 1'b0;
                    bus.RSP_DATA  <= '0;
                end

                default: begin
                    state         <= IDLE;
                    bus.REQ_READY <= 1'b1;
                    bus.M_REQ     <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lsu_mem_initiator.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_initiator
// Directed bench for lsu_mem_initiator. u_dut (TIMEOUT=255) carries the
// functional sequence; u_dut_to (TIMEOUT=4) carries the timeout case.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_lsu_mem_initiator;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    lsu_mem_initiator_if #(.AW(32)) bif ();
    lsu_mem_initiator_if #(.AW(32)) bif4 ();

    lsu_mem_initiator #(.TIMEOUT(255), .AW(32)) u_dut (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bif)
    );

    lsu_mem_initiator #(.TIMEOUT(4), .AW(32)) u_dut_to (
        .CLK     (clk),
        .RESET_N (rst_n),
        .bus     (bif4)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic issue(input logic mrd, input logic mwrt, input logic [2:0] f3,
                         input logic [31:0] addr, input logic [31:0] wd);
        check("req_ready_idle", bif.REQ_READY, 1);
        bif.REQ_VALID = 1'b1;
        bif.MRd       = mrd;
        bif.MWrt      = mwrt;
        bif.FUNC3     = f3;
        bif.IN_ADDR   = addr;
        bif.W_DATA    = wd;
        step();
        bif.REQ_VALID = 1'b0;
        bif.MRd       = 1'b0;
        bif.MWrt      = 1'b0;
        check("req_ready_busy", bif.REQ_READY, 0);
    endtask

    // One memory beat: check the request, optionally stall the grant, then
    // return M_RVALID rv_dly cycles after the grant.
    task automatic beat(input logic [29:0] exp_addr, input logic exp_we,
                        input logic [3:0] exp_strb, input logic [31:0] exp_wdata,
                        input logic [31:0] rdata, input int gnt_dly, input int rv_dly);
        int n = 0;
        while (!bif.M_REQ && n < 20) begin
            step();
            n++;
        end
        check("m_req_up", bif.M_REQ, 1);
        check("m_addr", bif.M_ADDR, exp_addr);
        check("m_we", bif.M_WE, exp_we);
        check("m_wstrb", bif.M_WSTRB, exp_strb);
        if (exp_we) check("m_wdata", bif.M_WDATA, exp_wdata);
        for (int i = 0; i < gnt_dly; i++) begin
            bif.M_RVALID = 1'b1;           // stray completion, must be ignored
            bif.M_RDATA  = 32'hBAD0BAD0;
            step();
            bif.M_RVALID = 1'b0;
            check("m_req_held", bif.M_REQ, 1);
            check("m_addr_held", bif.M_ADDR, exp_addr);
            check("req_ready_stall", bif.REQ_READY, 0);
        end
        bif.M_GNT = 1'b1;
        step();
        bif.M_GNT = 1'b0;
        check("m_req_drop", bif.M_REQ, 0);
        for (int i = 1; i < rv_dly; i++) begin
            check("no_rsp_wait", bif.RSP_VALID, 0);
            step();
        end
        bif.M_RVALID = 1'b1;
        bif.M_RDATA  = rdata;
        step();
        bif.M_RVALID = 1'b0;
        bif.M_RDATA  = 32'h0;
    endtask

    task automatic expect_rsp(input string tag, input logic [31:0] data, input logic err);
        check({tag, "_valid"}, bif.RSP_VALID, 1);
        check({tag, "_data"}, bif.RSP_DATA, data);
        check({tag, "_err"}, bif.RSP_ERR, err);
        check({tag, "_ready_low"}, bif.REQ_READY, 0);
        check({tag, "_no_req"}, bif.M_REQ, 0);
        step();
        check({tag, "_pulse"}, bif.RSP_VALID, 0);
        check({tag, "_ready_back"}, bif.REQ_READY, 1);
    endtask

    initial begin
        bif.REQ_VALID = 0; bif.MRd = 0; bif.MWrt = 0; bif.FUNC3 = 0;
        bif.IN_ADDR = 0; bif.W_DATA = 0; bif.M_GNT = 0; bif.M_RVALID = 0; bif.M_RDATA = 0;
        bif4.REQ_VALID = 0; bif4.MRd = 0; bif4.MWrt = 0; bif4.FUNC3 = 0;
        bif4.IN_ADDR = 0; bif4.W_DATA = 0; bif4.M_GNT = 0; bif4.M_RVALID = 0; bif4.M_RDATA = 0;

        // Reset state
        step();
        check("rst_req_ready", bif.REQ_READY, 1);
        check("rst_m_req", bif.M_REQ, 0);
        check("rst_rsp_valid", bif.RSP_VALID, 0);
        check("rst_m_wstrb", bif.M_WSTRB, 0);
        rst_n = 1'b1;
        step();

        // Aligned word store then load, zero-wait memory
        issue(0, 1, 3'b010, 32'h100, 32'hDEADBEEF);
        beat(30'h40, 1, 4'b1111, 32'hDEADBEEF, 32'h0, 0, 1);
        expect_rsp("sw", 32'h0, 0);
        issue(1, 0, 3'b010, 32'h100, 32'h0);
        beat(30'h40, 0, 4'b0000, 32'h0, 32'hDEADBEEF, 0, 1);
        expect_rsp("lw", 32'hDEADBEEF, 0);

        // Byte store / loads at offset 3
        issue(0, 1, 3'b000, 32'h103, 32'h80);
        beat(30'h40, 1, 4'b1000, 32'h80000000, 32'h0, 0, 1);
        expect_rsp("sb", 32'h0, 0);
        issue(1, 0, 3'b000, 32'h103, 32'h0);
        beat(30'h40, 0, 4'b0000, 32'h0, 32'h80ADBEEF, 0, 1);
        expect_rsp("lb", 32'hFFFFFF80, 0);
        issue(1, 0, 3'b100, 32'h103, 32'h0);
        beat(30'h40, 0, 4'b0000, 32'h0, 32'h80ADBEEF, 0, 1);
        expect_rsp("lbu", 32'h00000080, 0);

`ifndef LSU_MISALIGN_TRAP_EN
        // Split halfword load and store across words 0x40/0x41
        issue(1, 0, 3'b001, 32'h103, 32'h0);
        beat(30'h40, 0, 4'b0000, 32'h0, 32'hAB000000, 0, 1);
        beat(30'h41, 0, 4'b0000, 32'h0, 32'h000000CD, 0, 1);
        expect_rsp("lh_split", 32'hFFFFCDAB, 0);
        issue(0, 1, 3'b001, 32'h103, 32'h1234);
        beat(30'h40, 1, 4'b1000, 32'h34000000, 32'h0, 0, 1);
        beat(30'h41, 1, 4'b0001, 32'h00000012, 32'h0, 0, 1);
        expect_rsp("sh_split", 32'h0, 0);

        // Split word at offset 1
        issue(1, 0, 3'b010, 32'h101, 32'h0);
        beat(30'h40, 0, 4'b0000, 32'h0, 32'h44332211, 0, 1);
        beat(30'h41, 0, 4'b0000, 32'h0, 32'h88776655, 0, 1);
        expect_rsp("lw_split", 32'h55443322, 0);

        // Split at the top of the address space wraps to word 0
        issue(1, 0, 3'b001, 32'hFFFFFFFF, 32'h0);
        beat(30'h3FFFFFFF, 0, 4'b0000, 32'h0, 32'h11000000, 0, 1);
        beat(30'h00000000, 0, 4'b0000, 32'h0, 32'h00000022, 0, 1);
        expect_rsp("lh_wrap", 32'h00002211, 0);
`else
        // Word-crossing accesses trap without a beat
        issue(1, 0, 3'b001, 32'h103, 32'h0);
        expect_rsp("lh_trap", 32'h0, 1);
        issue(0, 1, 3'b001, 32'h103, 32'h1234);
        expect_rsp("sh_trap", 32'h0, 1);
        issue(1, 0, 3'b010, 32'h102, 32'h0);
        expect_rsp("lw_trap", 32'h0, 1);
        issue(1, 0, 3'b001, 32'hFFFFFFFF, 32'h0);
        expect_rsp("lh_wrap_trap", 32'h0, 1);
`endif

        // Grant and completion stalls, halfword zero-extend at offset 2
        issue(1, 0, 3'b101, 32'h102, 32'h0);
        beat(30'h40, 0, 4'b0000, 32'h0, 32'h9ABC0000, 3, 5);
        expect_rsp("lhu_stall", 32'h00009ABC, 0);
        check("lhu_stall_single", bif.RSP_VALID, 0);

        // Illegal requests: no beat, immediate error response
        issue(1, 0, 3'b011, 32'h100, 32'h0);
        expect_rsp("ill_f3", 32'h0, 1);
        issue(1, 1, 3'b010, 32'h100, 32'h0);
        expect_rsp("ill_rdwr", 32'h0, 1);
        issue(0, 1, 3'b100, 32'h100, 32'h55);
        expect_rsp("ill_store", 32'h0, 1);

        // Valid without MRd/MWrt is not accepted; stray M_RVALID in IDLE ignored
        bif.REQ_VALID = 1'b1;
        bif.M_RVALID  = 1'b1;
        step();
        bif.M_RVALID  = 1'b0;
        check("noop_ready", bif.REQ_READY, 1);
        check("noop_no_req", bif.M_REQ, 0);
        step();
        bif.REQ_VALID = 1'b0;
        check("noop_no_rsp", bif.RSP_VALID, 0);

        // Timeout on the TIMEOUT=4 instance
        bif4.REQ_VALID = 1'b1;
        bif4.MRd       = 1'b1;
        bif4.FUNC3     = 3'b010;
        bif4.IN_ADDR   = 32'h100;
        step();
        bif4.REQ_VALID = 1'b0;
        bif4.MRd       = 1'b0;
        check("to_m_req", bif4.M_REQ, 1);
        bif4.M_GNT = 1'b1;
        step();
        bif4.M_GNT = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check("to_wait_no_rsp", bif4.RSP_VALID, 0);
            step();
        end
        check("to_rsp_valid", bif4.RSP_VALID, 1);
        check("to_rsp_err", bif4.RSP_ERR, 1);
        check("to_rsp_data", bif4.RSP_DATA, 0);
        step();
        check("to_ready_back", bif4.REQ_READY, 1);
        check("to_pulse", bif4.RSP_VALID, 0);

        // Reset while waiting for the first beat's completion
        issue(1, 0, 3'b010, 32'h100, 32'h0);
        check("rstw_m_req", bif.M_REQ, 1);
        bif.M_GNT = 1'b1;
        step();
        bif.M_GNT = 1'b0;
        check("rstw_in_wait", bif.REQ_READY, 0);
        rst_n = 1'b0;
        #1;
        check("rstw_ready_now", bif.REQ_READY, 1);
        check("rstw_m_req_now", bif.M_REQ, 0);
        check("rstw_rsp_now", bif.RSP_VALID, 0);
        step();
        rst_n = 1'b1;
        bif.M_RVALID = 1'b1;
        bif.M_RDATA  = 32'h12345678;
        step();
        bif.M_RVALID = 1'b0;
        check("rstw_no_rsp", bif.RSP_VALID, 0);
        check("rstw_ready_after", bif.REQ_READY, 1);
        step();
        check("rstw_no_rsp2", bif.RSP_VALID, 0);
        check("rstw_no_req2", bif.M_REQ, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
